// File: rtl/rca4_adder.sv
// 4-bit ripple-carry adder with a registered 5-bit result.
// Four full-adder stages feed five output flops, which are the only storage.

module rca4_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module rca4_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic Cout
);

  logic [3:0] a_vec;
  logic [3:0] b_vec;
  logic [4:0] carry;
  logic [3:0] sum_d;
  logic       cout_d;
  logic [3:0] sum_q;
  logic       cout_q;

  assign a_vec    = {A3, A2, A1, A0};
  assign b_vec    = {B3, B2, B1, B0};
  assign carry[0] = Cin;

  // Carry ripples strictly stage to stage; no lookahead terms.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      rca4_full_adder u_fa (
        .a_i (a_vec[gi]),
        .b_i (b_vec[gi]),
        .c_i (carry[gi]),
        .s_o (sum_d[gi]),
        .c_o (carry[gi+1])
      );
    end
  endgenerate

  assign cout_d = carry[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 4'b0000;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign S3   = sum_q[3];
  assign S2   = sum_q[2];
  assign S1   = sum_q[1];
  assign S0   = sum_q[0];
  assign Cout = cout_q;

endmodule

// File: tb/tb_rca4_adder.sv
// Directed and exhaustive checks of the registered 4-bit ripple-carry adder.

module tb_rca4_adder;

  logic clk;
  logic rst_n;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic Cin;
  logic S3, S2, S1, S0, Cout;
  logic [4:0] res;
  int total;
  int bad;

  assign res = {Cout, S3, S2, S1, S0};

  rca4_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A3   (A3),
    .A2   (A2),
    .A1   (A1),
    .A0   (A0),
    .B3   (B3),
    .B2   (B2),
    .B1   (B1),
    .B0   (B0),
    .Cin  (Cin),
    .S3   (S3),
    .S2   (S2),
    .S1   (S1),
    .S0   (S0),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    Cin = c;
  endtask

  // Inputs change on the falling edge; results are sampled 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);
    #1;
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL reset_initial got=%b want=00000", res);
    end
    repeat (3) step();
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL reset_edges got=%b want=00000", res);
    end
    $display("reset: res=%b", res);
  endtask

  task automatic test_zero;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    step();
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL zero got=%b want=00000", res);
    end
    $display("zero: 0000+0000+0 -> %b", res);
  endtask

  task automatic test_max;
    @(negedge clk);
    drive(4'b1111, 4'b1111, 1'b0);
    step();
    total++;
    if (res !== 5'b11110) begin
      bad++;
      $display("FAIL max got=%b want=11110", res);
    end
    $display("max: 1111+1111+0 -> %b", res);
  endtask

  task automatic test_ripple;
    @(negedge clk);
    drive(4'b1111, 4'b0000, 1'b1);
    step();
    total++;
    if (res !== 5'b10000) begin
      bad++;
      $display("FAIL ripple got=%b want=10000", res);
    end
    $display("ripple: 1111+0000+1 -> %b", res);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(4'b0101, 4'b1010, 1'b1);
    step();
    total++;
    if (res !== 5'b10000) begin
      bad++;
      $display("FAIL b2b_first got=%b want=10000", res);
    end
    $display("b2b first: 0101+1010+1 -> %b", res);
    @(negedge clk);
    drive(4'b0111, 4'b0001, 1'b0);
    step();
    total++;
    if (res !== 5'b01000) begin
      bad++;
      $display("FAIL b2b_second got=%b want=01000", res);
    end
    $display("b2b second: 0111+0001+0 -> %b", res);
  endtask

  task automatic test_hold_between_edges;
    @(negedge clk);
    drive(4'b0011, 4'b0100, 1'b0);
    step();
    drive(4'b1001, 4'b1001, 1'b1);
    #2;
    total++;
    if (res !== 5'b00111) begin
      bad++;
      $display("FAIL hold_between_edges got=%b want=00111", res);
    end
    step();
    total++;
    if (res !== 5'b10011) begin
      bad++;
      $display("FAIL hold_next_edge got=%b want=10011", res);
    end
    $display("hold: 0011+0100+0 held, then 1001+1001+1 -> %b", res);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(4'b1111, 4'b1111, 1'b0);
    step();
    total++;
    if (res !== 5'b11110) begin
      bad++;
      $display("FAIL rstmid_pre got=%b want=11110", res);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_async got=%b want=00000", res);
    end
    repeat (2) step();
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_held got=%b want=00000", res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (res !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_release_noedge got=%b want=00000", res);
    end
    step();
    total++;
    if (res !== 5'b11110) begin
      bad++;
      $display("FAIL rstmid_restore got=%b want=11110", res);
    end
    $display("reset mid: restored -> %b", res);
  endtask

  task automatic test_exhaustive;
    int errs;
    logic [4:0] want;
    errs = 0;
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      drive(v[7:4], v[3:0], v[8]);
      want = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      step();
      total++;
      if (res !== want) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL exhaustive a=%b b=%b cin=%b got=%b want=%b", v[7:4], v[3:0], v[8], res, want);
      end
    end
    $display("exhaustive: 512 vectors, %0d wrong", errs);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero();
    test_max();
    test_ripple();
    test_back_to_back();
    test_hold_between_edges();
    test_reset_mid();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
